// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the instruction/data memory-port arbiter.
// The word width matches the core-wide word length used by the RAM.
package mem_port_arbiter_pkg;

  localparam int DEFAULT_WORD_LEN = 32;
  localparam int ARB_CNT_LEN      = 3;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_RD_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic {
    ARB_PORT_I = 1'b0,
    ARB_PORT_D = 1'b1
  } arb_port_e;

endpackage

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Two-way round-robin picker: the requester that did not win last time
// is preferred when both ask. Purely combinational.
module arb_rr2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  arb_port_e  last,
  output logic [1:0] grant,
  output arb_port_e  winner
);

  // NOTE: every output gets a default before the case, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    grant  = 2'b00;
    winner = ARB_PORT_I;
    unique case (req)
      2'b01: begin
        grant  = 2'b01;
        winner = ARB_PORT_I;
      end
      2'b10: begin
        grant  = 2'b10;
        winner = ARB_PORT_D;
      end
      2'b11: begin
        if (last == ARB_PORT_I) begin
          grant  = 2'b10;
          winner = ARB_PORT_D;
        end else begin
          grant  = 2'b01;
          winner = ARB_PORT_I;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the instruction-fetch and
// data ports; one access at a time, read data routed back to its issuer.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_LEN   = DEFAULT_WORD_LEN,
  parameter int RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [WORD_LEN-1:0] i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [WORD_LEN-1:0] i_rdata,
  input  logic                d_req,
  input  logic [WORD_LEN-1:0] d_addr,
  input  logic                d_wen,
  input  logic [WORD_LEN-1:0] d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [WORD_LEN-1:0] d_rdata,
  output logic                mem_en,
  output logic                mem_wen,
  output logic [WORD_LEN-1:0] mem_addr,
  output logic [WORD_LEN-1:0] mem_wdata,
  input  logic [WORD_LEN-1:0] mem_rdata,
  output logic                busy
);

  localparam logic [ARB_CNT_LEN-1:0] CNT_LOAD = ARB_CNT_LEN'(RD_LATENCY - 1);

  arb_state_e             r_state, w_state_nxt;
  logic [ARB_CNT_LEN-1:0] r_cnt, w_cnt_nxt;
  arb_port_e              r_owner, w_owner_nxt;
  arb_port_e              r_last, w_last_nxt;

  logic [1:0] w_grant;
  arb_port_e  w_winner;
  logic       w_grant_en;
  logic       w_rd_done;
  logic       w_issue;
  logic       w_deliver;
  logic       w_d_win;

  arb_rr2 u_rr2 (
    .req    ({d_req, i_req}),
    .last   (r_last),
    .grant  (w_grant),
    .winner (w_winner)
  );

  assign w_grant_en = (r_state == ARB_IDLE) && (|w_grant);
  assign w_rd_done  = (r_state == ARB_RD_WAIT) && (r_cnt == '0);
  assign w_d_win    = (w_winner == ARB_PORT_D);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_cnt   <= '0;
      r_owner <= ARB_PORT_I;
      r_last  <= ARB_PORT_I;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_grant_en) begin
          w_last_nxt = w_winner;
          // Writes retire in the grant cycle; only reads occupy the port.
          if (!(w_d_win && d_wen)) begin
            w_owner_nxt = w_winner;
            w_cnt_nxt   = CNT_LOAD;
            w_state_nxt = ARB_RD_WAIT;
          end
        end
      end
      ARB_RD_WAIT: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // Strobes are gated by reset so nothing leaks out while rst_n is low.
  assign w_issue   = w_grant_en && rst_n;
  assign w_deliver = w_rd_done && rst_n;

  assign i_gnt     = w_issue && w_grant[0];
  assign d_gnt     = w_issue && w_grant[1];
  assign mem_en    = w_issue;
  assign mem_wen   = w_issue && w_d_win && d_wen;
  assign mem_addr  = w_issue ? (w_d_win ? d_addr : i_addr) : '0;
  assign mem_wdata = mem_wen ? d_wdata : '0;

  assign i_rvalid  = w_deliver && (r_owner == ARB_PORT_I);
  assign d_rvalid  = w_deliver && (r_owner == ARB_PORT_D);
  assign i_rdata   = i_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;

  assign busy      = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: randomized and directed traffic against a cycle-level
// reference built from the arbitration rules, plus a latency-1 instance.
module tb_mem_port_arbiter;

  localparam int W = 32;
  localparam int L = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         i_req, d_req, d_wen;
  logic [W-1:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic         i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_wen, busy;
  logic [W-1:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  logic         l1_i_req, l1_d_req, l1_d_wen;
  logic [W-1:0] l1_i_addr, l1_d_addr, l1_d_wdata, l1_mem_rdata;
  logic         l1_i_gnt, l1_i_rvalid, l1_d_gnt, l1_d_rvalid, l1_mem_en, l1_mem_wen, l1_busy;
  logic [W-1:0] l1_i_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata;

  mem_port_arbiter #(.WORD_LEN(W), .RD_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wen(d_wen), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.WORD_LEN(W), .RD_LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .i_req(l1_i_req), .i_addr(l1_i_addr), .i_gnt(l1_i_gnt), .i_rvalid(l1_i_rvalid), .i_rdata(l1_i_rdata),
    .d_req(l1_d_req), .d_addr(l1_d_addr), .d_wen(l1_d_wen), .d_wdata(l1_d_wdata),
    .d_gnt(l1_d_gnt), .d_rvalid(l1_d_rvalid), .d_rdata(l1_d_rdata),
    .mem_en(l1_mem_en), .mem_wen(l1_mem_wen), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(l1_mem_rdata), .busy(l1_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // RAM environment seen by the latency-2 instance, and the reference copy.
  typedef struct { int due; logic [W-1:0] data; } rd_t;
  rd_t          env_q[$];
  logic [W-1:0] env_mem [logic [W-1:0]];
  logic [W-1:0] ref_mem [logic [W-1:0]];

  // Reference state: who went last, when the port is free, pending read.
  int           m_last    = 0;
  int           m_free_at = 0;
  int           m_rd_due  = -1;
  int           m_rd_port = 0;
  logic [W-1:0] m_rd_data = '0;
  int           m_busy_lo = 0;
  int           m_busy_hi = -1;
  int           m_win     = -1;

  logic         obs_i_gnt, obs_d_gnt, obs_i_rvalid, obs_d_rvalid, obs_mem_en, obs_mem_wen, obs_busy;
  logic [W-1:0] obs_i_rdata, obs_mem_addr, obs_mem_wdata;
  logic         o1_i_gnt, o1_i_rvalid, o1_d_gnt, o1_d_rvalid, o1_mem_en, o1_mem_wen, o1_busy;
  logic [W-1:0] o1_i_rdata, o1_d_rdata, o1_mem_addr, o1_mem_wdata;

  function automatic logic [W-1:0] init_word(input logic [W-1:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [W-1:0] env_read(input logic [W-1:0] a);
    return env_mem.exists(a) ? env_mem[a] : init_word(a);
  endfunction

  function automatic logic [W-1:0] ref_read(input logic [W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic preload(input logic [W-1:0] a, input logic [W-1:0] v);
    env_mem[a] = v;
    ref_mem[a] = v;
  endtask

  // One clock cycle: present RAM data, compare all outputs with the
  // reference, let the RAM observe the strobe, then advance both.
  task automatic run_cycle();
    int           win;
    bit           e_ig, e_dg, e_ir, e_dr, e_en, e_wen, e_busy;
    logic [W-1:0] e_addr, e_wdata, e_ird, e_drd, a;
    mem_rdata = $urandom;
    foreach (env_q[k]) if (env_q[k].due == cyc) mem_rdata = env_q[k].data;
    #2;
    win    = -1;
    e_ir   = 1'b0;
    e_dr   = 1'b0;
    e_busy = (cyc >= m_busy_lo) && (cyc <= m_busy_hi);
    if (rst_n) begin
      if (cyc >= m_free_at && (i_req || d_req))
        win = (i_req && d_req) ? (1 - m_last) : (d_req ? 1 : 0);
      if (m_rd_due == cyc) begin
        e_ir = (m_rd_port == 0);
        e_dr = (m_rd_port == 1);
      end
    end
    e_ig    = (win == 0);
    e_dg    = (win == 1);
    e_en    = (win >= 0);
    e_wen   = (win == 1) && d_wen;
    e_addr  = (win == 1) ? d_addr : ((win == 0) ? i_addr : '0);
    e_wdata = e_wen ? d_wdata : '0;
    e_ird   = e_ir ? m_rd_data : '0;
    e_drd   = e_dr ? m_rd_data : '0;

    n_tests++;
    if ({i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_wen, busy} !==
        {e_ig, e_dg, e_ir, e_dr, e_en, e_wen, e_busy}) begin
      n_fail++;
      $display("FAIL ctrl cyc=%0d got igdg_irdr_en_wen_busy=%b want %b", cyc,
               {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_wen, busy},
               {e_ig, e_dg, e_ir, e_dr, e_en, e_wen, e_busy});
    end
    n_tests++;
    if (mem_addr !== e_addr) begin
      n_fail++;
      $display("FAIL mem_addr cyc=%0d got %h want %h", cyc, mem_addr, e_addr);
    end
    n_tests++;
    if (mem_wdata !== e_wdata) begin
      n_fail++;
      $display("FAIL mem_wdata cyc=%0d got %h want %h", cyc, mem_wdata, e_wdata);
    end
    n_tests++;
    if (i_rdata !== e_ird) begin
      n_fail++;
      $display("FAIL i_rdata cyc=%0d got %h want %h", cyc, i_rdata, e_ird);
    end
    n_tests++;
    if (d_rdata !== e_drd) begin
      n_fail++;
      $display("FAIL d_rdata cyc=%0d got %h want %h", cyc, d_rdata, e_drd);
    end

    {obs_i_gnt, obs_d_gnt, obs_i_rvalid, obs_d_rvalid} = {i_gnt, d_gnt, i_rvalid, d_rvalid};
    {obs_mem_en, obs_mem_wen, obs_busy} = {mem_en, mem_wen, busy};
    obs_i_rdata   = i_rdata;
    obs_mem_addr  = mem_addr;
    obs_mem_wdata = mem_wdata;
    {o1_i_gnt, o1_i_rvalid, o1_d_gnt, o1_d_rvalid} = {l1_i_gnt, l1_i_rvalid, l1_d_gnt, l1_d_rvalid};
    {o1_mem_en, o1_mem_wen, o1_busy} = {l1_mem_en, l1_mem_wen, l1_busy};
    o1_i_rdata   = l1_i_rdata;
    o1_d_rdata   = l1_d_rdata;
    o1_mem_addr  = l1_mem_addr;
    o1_mem_wdata = l1_mem_wdata;

    if (mem_en === 1'b1 && mem_wen === 1'b0) env_q.push_back('{cyc + L, env_read(mem_addr)});
    if (mem_en === 1'b1 && mem_wen === 1'b1) env_mem[mem_addr] = mem_wdata;

    if (!rst_n) begin
      m_last    = 0;
      m_rd_due  = -1;
      m_busy_hi = -1;
      m_free_at = cyc + 1;
    end else if (win >= 0) begin
      m_last = win;
      if (win == 1 && d_wen) begin
        ref_mem[d_addr] = d_wdata;
        m_free_at = cyc + 1;
      end else begin
        a         = (win == 1) ? d_addr : i_addr;
        m_rd_port = win;
        m_rd_due  = cyc + L;
        m_rd_data = ref_read(a);
        m_busy_lo = cyc + 1;
        m_busy_hi = cyc + L;
        m_free_at = cyc + L + 1;
      end
    end
    m_win = win;

    @(posedge clk);
    cyc++;
    #1;
    while (env_q.size() > 0 && env_q[0].due < cyc) void'(env_q.pop_front());
  endtask

  task automatic idle_inputs();
    i_req = 0; d_req = 0; d_wen = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    i_req = 1; i_addr = 32'h44; d_req = 1; d_addr = 32'h88; d_wen = 0;
    @(posedge clk);
    cyc++;
    #1;
    repeat (2) begin
      run_cycle();
      n_tests++;
      if ({obs_i_gnt, obs_d_gnt, obs_mem_en, obs_i_rvalid, obs_d_rvalid} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_quiet got %b want 00000",
                 {obs_i_gnt, obs_d_gnt, obs_mem_en, obs_i_rvalid, obs_d_rvalid});
      end
    end
    rst_n = 1;
    idle_inputs();
    run_cycle();
    n_tests++;
    if (obs_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b want 0", obs_busy);
    end
  endtask

  task automatic test_single_read();
    preload(32'h100, 32'hDEAD_BEEF);
    i_req = 1; i_addr = 32'h100;
    run_cycle();
    n_tests++;
    if ({obs_i_gnt, obs_mem_en, obs_mem_addr} !== {2'b11, 32'h100}) begin
      n_fail++;
      $display("FAIL rd_grant got gnt=%b en=%b addr=%h want 1 1 100", obs_i_gnt, obs_mem_en, obs_mem_addr);
    end
    i_req = 0; i_addr = '0;
    run_cycle();
    n_tests++;
    if ({obs_busy, obs_i_rvalid} !== 2'b10) begin
      n_fail++;
      $display("FAIL rd_wait got busy,rvalid=%b want 10", {obs_busy, obs_i_rvalid});
    end
    run_cycle();
    n_tests++;
    if ({obs_busy, obs_i_rvalid, obs_d_rvalid, obs_i_rdata} !== {3'b110, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL rd_data got busy=%b iv=%b dv=%b data=%h want 1 1 0 deadbeef",
               obs_busy, obs_i_rvalid, obs_d_rvalid, obs_i_rdata);
    end
    run_cycle();
    n_tests++;
    if ({obs_busy, obs_i_rvalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL rd_after got busy,rvalid=%b want 00", {obs_busy, obs_i_rvalid});
    end
  endtask

  task automatic test_back_to_back();
    d_req = 1; d_wen = 1; d_addr = 32'h200; d_wdata = 32'h1234_5678;
    for (int k = 0; k < 3; k++) begin
      run_cycle();
      n_tests++;
      if ({obs_d_gnt, obs_mem_en, obs_mem_wen, obs_busy, obs_mem_addr, obs_mem_wdata} !==
          {4'b1110, 32'h200, 32'h1234_5678}) begin
        n_fail++;
        $display("FAIL b2b_write%0d got g=%b en=%b we=%b busy=%b a=%h d=%h want 1 1 1 0 200 12345678",
                 k, obs_d_gnt, obs_mem_en, obs_mem_wen, obs_busy, obs_mem_addr, obs_mem_wdata);
      end
    end
    idle_inputs();
    i_req = 1; i_addr = 32'h200;
    run_cycle();
    i_req = 0;
    repeat (2) run_cycle();
    n_tests++;
    if ({obs_i_rvalid, obs_i_rdata} !== {1'b1, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL readback got v=%b data=%h want 1 12345678", obs_i_rvalid, obs_i_rdata);
    end
    run_cycle();
  endtask

  task automatic test_fairness();
    int seq_port[6];
    int seq_cyc[6];
    int n_g = 0;
    rst_n = 0;
    run_cycle();
    rst_n = 1;
    i_req = 1; i_addr = {$urandom_range(0, 15), 2'b00};
    d_req = 1; d_addr = {$urandom_range(0, 15), 2'b00}; d_wen = 0;
    for (int t = 0; t < 40 && n_g < 6; t++) begin
      run_cycle();
      if (obs_i_gnt === 1'b1) begin
        seq_port[n_g] = 0; seq_cyc[n_g] = cyc; n_g++;
        i_addr = {$urandom_range(0, 15), 2'b00};
      end else if (obs_d_gnt === 1'b1) begin
        seq_port[n_g] = 1; seq_cyc[n_g] = cyc; n_g++;
        d_addr = {$urandom_range(0, 15), 2'b00};
      end
    end
    n_tests++;
    if (n_g != 6) begin
      n_fail++;
      $display("FAIL fair_count got %0d grants want 6 within 40 cycles", n_g);
    end
    for (int k = 0; k < n_g; k++) begin
      n_tests++;
      if (seq_port[k] != ((k % 2 == 0) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL fair_order grant%0d got port %0d want %0d", k, seq_port[k], (k % 2 == 0) ? 1 : 0);
      end
      if (k > 0) begin
        n_tests++;
        if (seq_cyc[k] - seq_cyc[k-1] != L + 1) begin
          n_fail++;
          $display("FAIL fair_spacing grant%0d got %0d want %0d", k, seq_cyc[k] - seq_cyc[k-1], L + 1);
        end
      end
    end
    idle_inputs();
    repeat (L + 2) run_cycle();
  endtask

  task automatic test_req_during_wait();
    int rv_c = -1;
    int g_c  = -1;
    d_req = 1; d_wen = 0; d_addr = 32'h3C;
    run_cycle();
    n_tests++;
    if (obs_d_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_dgnt got %b want 1", obs_d_gnt);
    end
    d_req = 0;
    i_req = 1; i_addr = 32'h10;
    for (int t = 0; t < 10 && g_c < 0; t++) begin
      run_cycle();
      if (obs_d_rvalid === 1'b1) rv_c = cyc;
      if (obs_i_gnt === 1'b1) g_c = cyc;
    end
    n_tests++;
    if (rv_c < 0 || g_c != rv_c + 1) begin
      n_fail++;
      $display("FAIL wait_igrant got rvalid@%0d gnt@%0d want gnt one cycle after rvalid", rv_c, g_c);
    end
    idle_inputs();
    repeat (L + 1) run_cycle();
  endtask

  task automatic test_reset_mid_read();
    int n_rv = 0;
    i_req = 1; i_addr = 32'h24;
    run_cycle();
    n_tests++;
    if (obs_i_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_gnt got %b want 1", obs_i_gnt);
    end
    i_addr = 32'h28;
    rst_n = 0;
    run_cycle();
    n_tests++;
    if ({obs_i_gnt, obs_d_gnt, obs_mem_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL midrst_quiet got %b want 000", {obs_i_gnt, obs_d_gnt, obs_mem_en});
    end
    rst_n = 1;
    run_cycle();
    n_tests++;
    if ({obs_busy, obs_i_rvalid, obs_i_gnt} !== 3'b001) begin
      n_fail++;
      $display("FAIL midrst_release got busy,rvalid,gnt=%b want 001", {obs_busy, obs_i_rvalid, obs_i_gnt});
    end
    i_req = 0;
    repeat (L + 1) begin
      run_cycle();
      if (obs_i_rvalid === 1'b1) n_rv++;
    end
    n_tests++;
    if (n_rv != 1) begin
      n_fail++;
      $display("FAIL midrst_rvalids got %0d want 1", n_rv);
    end
  endtask

  task automatic test_latency1();
    idle_inputs();
    l1_i_req = 1; l1_i_addr = 32'h40; l1_mem_rdata = '0;
    run_cycle();
    n_tests++;
    if ({o1_i_gnt, o1_mem_en, o1_mem_wen} !== 3'b110) begin
      n_fail++;
      $display("FAIL l1_igrant got gnt,en,wen=%b want 110", {o1_i_gnt, o1_mem_en, o1_mem_wen});
    end
    l1_i_req = 0;
    l1_d_req = 1; l1_d_wen = 1; l1_d_addr = 32'h80; l1_d_wdata = 32'hCAFE_F00D;
    l1_mem_rdata = 32'h0BAD_F00D;
    run_cycle();
    n_tests++;
    if ({o1_i_rvalid, o1_busy, o1_d_gnt, o1_mem_wen, o1_d_rvalid, o1_i_rdata, o1_d_rdata} !==
        {5'b11000, 32'h0BAD_F00D, 32'h0}) begin
      n_fail++;
      $display("FAIL l1_rvalid got iv=%b busy=%b dg=%b we=%b dv=%b id=%h dd=%h want 1 1 0 0 0 0badf00d 0",
               o1_i_rvalid, o1_busy, o1_d_gnt, o1_mem_wen, o1_d_rvalid, o1_i_rdata, o1_d_rdata);
    end
    l1_mem_rdata = '0;
    run_cycle();
    n_tests++;
    if ({o1_d_gnt, o1_mem_wen, o1_i_rvalid, o1_mem_addr, o1_mem_wdata} !==
        {3'b110, 32'h80, 32'hCAFE_F00D}) begin
      n_fail++;
      $display("FAIL l1_write got g=%b we=%b iv=%b a=%h d=%h want 1 1 0 80 cafef00d",
               o1_d_gnt, o1_mem_wen, o1_i_rvalid, o1_mem_addr, o1_mem_wdata);
    end
    l1_d_req = 0; l1_d_wen = 0;
    run_cycle();
    n_tests++;
    if ({o1_d_gnt, o1_mem_wen, o1_mem_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL l1_after got g,we,en=%b want 000", {o1_d_gnt, o1_mem_wen, o1_mem_en});
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if (!i_req) begin
        i_addr = $urandom;
        if ($urandom_range(0, 1) == 1) begin
          i_req  = 1;
          i_addr = {$urandom_range(0, 15), 2'b00};
        end
      end
      if (!d_req) begin
        d_addr  = $urandom;
        d_wen   = $urandom_range(0, 1);
        d_wdata = $urandom;
        if ($urandom_range(0, 1) == 1) begin
          d_req  = 1;
          d_addr = {$urandom_range(0, 15), 2'b00};
        end
      end
      run_cycle();
      if (m_win == 0) i_req = 0;
      if (m_win == 1) d_req = 0;
    end
    idle_inputs();
    repeat (L + 2) run_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    mem_rdata = '0;
    l1_i_req = 0; l1_d_req = 0; l1_d_wen = 0;
    l1_i_addr = '0; l1_d_addr = '0; l1_d_wdata = '0; l1_mem_rdata = '0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_fairness();
    test_req_during_wait();
    test_reset_mid_read();
    test_latency1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
